// File: rtl/traffic_mode_ctrl.sv
// Traffic-mode sequencer: DAY/NIGHT base modes, timed pedestrian phase and emergency pre-emption with hold.
// Optional EMG entry counter output emg_count when TRAFFIC_MODE_STATS_EN is defined.
//
// state    | meaning
// ST_DAY   | day base mode, minimum dwell before non-emergency exit
// ST_NIGHT | night base mode, minimum dwell before non-emergency exit
// ST_PED   | pedestrian phase, fixed duration
// ST_EMG   | emergency pre-emption, held after emg_req falls
module traffic_mode_ctrl #(
    parameter int PED_CH    = 4,
    parameter int CNT_W     = 8,
    parameter int MIN_DWELL = 8,
    parameter int PED_TIME  = 16,
    parameter int EMG_HOLD  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              day_night,
    input  logic [PED_CH-1:0] ped_req,
    input  logic              emg_req,
    output logic [1:0]        mode,
    output logic              mode_change,
    output logic [PED_CH-1:0] ped_ack,
    output logic [PED_CH-1:0] ped_pending
`ifdef TRAFFIC_MODE_STATS_EN
    ,
    output logic [15:0]       emg_count
`endif
);

    typedef enum logic [1:0] {
        ST_DAY   = 2'b00,
        ST_NIGHT = 2'b01,
        ST_PED   = 2'b10,
        ST_EMG   = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(MIN_DWELL - 1);
    localparam logic [CNT_W-1:0] PED_LAST   = CNT_W'(PED_TIME - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(EMG_HOLD);

    state_t            state_q, state_d;
    state_t            base_mode;
    logic [CNT_W-1:0]  dwell_q, dwell_d;
    logic [CNT_W-1:0]  hold_q, hold_d;
    logic [PED_CH-1:0] pending_q, pending_d;
    logic [PED_CH-1:0] ack_q, ack_d;
    logic [PED_CH-1:0] pend_all;
    logic              mode_change_q, mode_change_d;
    logic              enter_ped;
    logic              enter_emg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_NIGHT;
            dwell_q       <= '0;
            hold_q        <= '0;
            pending_q     <= '0;
            ack_q         <= '0;
            mode_change_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            dwell_q       <= dwell_d;
            hold_q        <= hold_d;
            pending_q     <= pending_d;
            ack_q         <= ack_d;
            mode_change_q <= mode_change_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pend_all  = pending_q | ped_req;
        base_mode = day_night ? ST_DAY : ST_NIGHT;

        case (state_q)
            ST_DAY, ST_NIGHT: begin
                if (emg_req) begin
                    state_d = ST_EMG;
                end else if (dwell_q >= DWELL_LAST) begin
                    if (|pend_all) begin
                        state_d = ST_PED;
                    end else if (base_mode != state_q) begin
                        state_d = base_mode;
                    end
                end
            end
            ST_PED: begin
                if (emg_req) begin
                    state_d = ST_EMG;
                end else if (dwell_q == PED_LAST) begin
                    state_d = base_mode;
                end
            end
            ST_EMG: begin
                if (!emg_req && hold_q == '0) begin
                    state_d = (|pend_all) ? ST_PED : base_mode;
                end
            end
            default: state_d = ST_NIGHT;
        endcase

        enter_ped     = (state_d == ST_PED) && (state_q != ST_PED);
        enter_emg     = (state_d == ST_EMG) && (state_q != ST_EMG);
        mode_change_d = (state_d != state_q);

        if (state_d != state_q) begin
            dwell_d = '0;
        end else if (dwell_q != '1) begin
            dwell_d = dwell_q + CNT_W'(1);
        end else begin
            dwell_d = dwell_q;
        end

        // Every EMG entry happens with emg_req high, so the hold is always freshly loaded.
        if (emg_req) begin
            hold_d = HOLD_LOAD;
        end else if (state_q == ST_EMG && hold_q != '0) begin
            hold_d = hold_q - CNT_W'(1);
        end else begin
            hold_d = hold_q;
        end

        // Requests arriving on the PED entry cycle are acknowledged, not re-latched.
        pending_d = enter_ped ? '0 : pend_all;
        ack_d     = enter_ped ? pend_all : '0;
    end

    assign mode        = state_q;
    assign mode_change = mode_change_q;
    assign ped_ack     = ack_q;
    assign ped_pending = pending_q;

`ifdef TRAFFIC_MODE_STATS_EN
    logic [15:0] emg_count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            emg_count_q <= '0;
        end else if (enter_emg && emg_count_q != 16'hFFFF) begin
            emg_count_q <= emg_count_q + 16'd1;
        end
    end

    assign emg_count = emg_count_q;
`else
    logic unused_enter_emg;
    assign unused_enter_emg = enter_emg;
`endif

endmodule

// File: tb/tb_traffic_mode_ctrl.sv
// Scoreboard bench for traffic_mode_ctrl: expected mode changes are queued with their target cycle
// when stimulus is applied and popped whenever the DUT pulses mode_change.
module tb_traffic_mode_ctrl;

    logic       clk;
    logic       rst;
    logic       day_night;
    logic [3:0] ped_req;
    logic       emg_req;
    logic [1:0] mode;
    logic       mode_change;
    logic [3:0] ped_ack;
    logic [3:0] ped_pending;
`ifdef TRAFFIC_MODE_STATS_EN
    logic [15:0] emg_count;
`endif

    typedef struct {
        logic [1:0] mode;
        logic [3:0] ack;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc;
    int   n_chk;
    int   n_bad;
    int   exp_emg;

    traffic_mode_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .day_night   (day_night),
        .ped_req     (ped_req),
        .emg_req     (emg_req),
        .mode        (mode),
        .mode_change (mode_change),
        .ped_ack     (ped_ack),
        .ped_pending (ped_pending)
`ifdef TRAFFIC_MODE_STATS_EN
        ,
        .emg_count   (emg_count)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    task automatic check_val(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic expect_chg(input logic [1:0] m, input logic [3:0] a, input int c);
        exp_t e;
        e.mode = m;
        e.ack  = a;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
                check_val("missed_chg", cyc, exp_q[0].cyc);
                void'(exp_q.pop_front());
            end
            if (mode_change) begin
                if (exp_q.size() == 0) begin
                    check_val("unexp_chg_mode", int'(mode), -1);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check_val("chg_mode", int'(mode), int'(e.mode));
                    check_val("chg_ack", int'(ped_ack), int'(e.ack));
                    check_val("chg_cyc", cyc, e.cyc);
                    if (e.mode == 2'b11) begin
                        exp_emg++;
`ifdef TRAFFIC_MODE_STATS_EN
                        check_val("emg_count", int'(emg_count), exp_emg);
`endif
                    end
                end
            end else if (ped_ack != 4'b0000) begin
                check_val("stray_ack", int'(ped_ack), 0);
            end
        end
    end

    task automatic do_reset(input logic dn);
        rst       = 1'b0;
        emg_req   = 1'b0;
        ped_req   = 4'b0000;
        day_night = dn;
        exp_q.delete();
        exp_emg   = 0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_mode", int'(mode), 1);
        check_val("rst_chg", int'(mode_change), 0);
        check_val("rst_ack", int'(ped_ack), 0);
        check_val("rst_pend", int'(ped_pending), 0);
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk = 0;
        n_bad = 0;

        // Night hold with no requests: never leaves NIGHT.
        do_reset(1'b0);
        for (int i = 1; i <= 20; i++) begin
            wait_cyc(i);
            check_val("t1_mode", int'(mode), 1);
            check_val("t1_chg", int'(mode_change), 0);
        end
        check_val("t1_q_empty", exp_q.size(), 0);

        // Day select from reset, then a pedestrian pulse in DAY dwell 2.
        do_reset(1'b1);
        expect_chg(2'b00, 4'b0000, 8);
        wait_cyc(7);
        check_val("t2_mode_pre", int'(mode), 1);
        wait_cyc(10);
        ped_req = 4'b0100;
        expect_chg(2'b10, 4'b0100, 16);
        expect_chg(2'b00, 4'b0000, 32);
        wait_cyc(11);
        ped_req = 4'b0000;
        for (int i = 11; i <= 15; i++) begin
            wait_cyc(i);
            check_val("t3_pend", int'(ped_pending), 4'b0100);
        end
        wait_cyc(16);
        check_val("t3_pend_clr", int'(ped_pending), 0);

        // Emergency during PED dwell 5, with a ped request latched during EMG.
        wait_cyc(33);
        ped_req = 4'b0010;
        expect_chg(2'b10, 4'b0010, 40);
        wait_cyc(34);
        ped_req = 4'b0000;
        wait_cyc(45);
        emg_req = 1'b1;
        expect_chg(2'b11, 4'b0000, 46);
        expect_chg(2'b10, 4'b0001, 53);
        expect_chg(2'b00, 4'b0000, 69);
        wait_cyc(47);
        ped_req = 4'b0001;
        wait_cyc(48);
        ped_req = 4'b0000;
        emg_req = 1'b0;
        check_val("t4_pend", int'(ped_pending), 4'b0001);
        wait_cyc(52);
        check_val("t4_mode_hold", int'(mode), 3);
        wait_cyc(70);
        check_val("t4_q_empty", exp_q.size(), 0);

        // Same-edge emergency and ped request in NIGHT dwell 0.
        do_reset(1'b0);
        emg_req = 1'b1;
        ped_req = 4'b1000;
        expect_chg(2'b11, 4'b0000, 1);
        expect_chg(2'b10, 4'b1000, 7);
        expect_chg(2'b01, 4'b0000, 23);
        wait_cyc(1);
        ped_req = 4'b0000;
        check_val("t5_pend", int'(ped_pending), 4'b1000);
        wait_cyc(2);
        emg_req = 1'b0;
        wait_cyc(24);
        day_night = 1'b1;
        expect_chg(2'b00, 4'b0000, 31);
        wait_cyc(32);
        emg_req = 1'b1;
        expect_chg(2'b11, 4'b0000, 33);
        expect_chg(2'b00, 4'b0000, 38);
        wait_cyc(33);
        emg_req = 1'b0;

        // Reset in the middle of EMG with a pending request.
        wait_cyc(40);
        emg_req = 1'b1;
        expect_chg(2'b11, 4'b0000, 41);
        wait_cyc(41);
        ped_req = 4'b0100;
        wait_cyc(42);
        ped_req = 4'b0000;
        wait_cyc(43);
        check_val("t6_pend_pre", int'(ped_pending), 4'b0100);
        check_val("t6_mode_pre", int'(mode), 3);
        check_val("t6_q_empty", exp_q.size(), 0);
`ifdef TRAFFIC_MODE_STATS_EN
        check_val("t6_emg_pre", int'(emg_count), exp_emg);
`endif
        #2;
        rst = 1'b0;
        #1;
        check_val("t6_mode_rst", int'(mode), 1);
        check_val("t6_pend_rst", int'(ped_pending), 0);
        check_val("t6_chg_rst", int'(mode_change), 0);
`ifdef TRAFFIC_MODE_STATS_EN
        check_val("t6_emg_rst", int'(emg_count), 0);
`endif
        emg_req = 1'b0;
        repeat (2) @(posedge clk);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
